// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared state encoding and 2-input truth tables
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit k is the expected output for input code k, {X1,X2} with X1 as MSB.
  localparam logic [3:0] NOR2_TT  = 4'b0001;
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] OR2_TT   = 4'b1110;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - counts settle cycles, flags the last cycle of a hold window
module settle_timer #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(HOLD - 1);

  logic [7:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear || expired) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign expired = (hold_cnt == LAST);

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps all input codes of a gate and checks its output
module gate_sweep_checker
  import gate_test_pkg::*;
#(
  parameter int                 N_IN  = 2,
  parameter int                 HOLD  = 4,
  parameter logic [2**N_IN-1:0] TRUTH = NOR2_TT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_dut,
  output logic [N_IN-1:0] x,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_code
);

  localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] CODE_ONE  = 1;
  localparam logic [N_IN:0]   ERR_ONE   = 1;

  state_t          state;
  logic [N_IN-1:0] code;
  logic            timer_clear;
  logic            expired;
  logic            miss;

  assign timer_clear = (state != DRIVE);

  settle_timer #(.HOLD(HOLD)) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .expired (expired)
  );

  // Case inequality so an X or Z from the gate counts as a failure.
  assign miss = (y_dut !== TRUTH[code]);
  assign x    = code;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      code             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_code  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= DRIVE;
            code             <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_code  <= '0;
          end
        end
        DRIVE: begin
          if (expired) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (miss) begin
            err_count <= err_count + ERR_ONE;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_code  <= code;
            end
          end
          if (code == LAST_CODE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !miss;
          end else begin
            state <= DRIVE;
            code  <= code + CODE_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - randomized scoreboard bench for gate_sweep_checker
module tb_gate_sweep_checker;
  import gate_test_pkg::*;

  typedef struct {
    int   inst;
    int   s;
    int   err;
    logic ffv;
    int   ffc;
    logic pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       y_a, y_b;
  logic [1:0] x_a, x_b, ffc_a, ffc_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
  logic [2:0] err_a, err_b;

  gate_sweep_checker #(.N_IN(2), .HOLD(4), .TRUTH(NOR2_TT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_dut(y_a), .x(x_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_code(ffc_a)
  );

  gate_sweep_checker #(.N_IN(2), .HOLD(2), .TRUTH(NOR2_TT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_dut(y_b), .x(x_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_code(ffc_b)
  );

  // Gate under test model: NOR, stuck-at-1, stuck-at-0 or NOR with flipped codes,
  // optionally seeing its input three cycles late.
  int         mode = 0;
  int         dly = 0;
  logic [3:0] flip = 4'd0;
  logic [3:0] tt_nor = 4'b0001;
  logic [5:0] hist_a = '0, hist_b = '0;

  function automatic logic gate_fn(logic [1:0] v, int md, logic [3:0] fl, logic [3:0] t);
    case (md)
      0:       return t[v];
      1:       return 1'b1;
      2:       return 1'b0;
      default: return t[v] ^ fl[v];
    endcase
  endfunction

  always @(posedge clk) begin
    hist_a <= {hist_a[3:0], x_a};
    hist_b <= {hist_b[3:0], x_b};
  end

  assign y_a = gate_fn((dly == 0) ? x_a : hist_a[5:4], mode, flip, tt_nor);
  assign y_b = gate_fn((dly == 0) ? x_b : hist_b[5:4], mode, flip, tt_nor);

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   prev_x [2] = '{0, 0};
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: the sample of code k sees the gate driven with whatever x was
  // d cycles earlier; before the start edge x still holds px.
  function automatic exp_t predict(int inst, int s, int px, int md, int d, logic [3:0] fl);
    exp_t       e;
    int         h;
    int         j;
    int         seen;
    logic [3:0] t;
    t = 4'b0001;
    h = inst ? 2 : 4;
    e.inst = inst; e.s = s; e.err = 0; e.ffv = 1'b0; e.ffc = 0;
    for (int k = 0; k < 4; k++) begin
      j    = (h + 1) * k + h - d;
      seen = (j < 0) ? px : j / (h + 1);
      if (gate_fn(2'(seen), md, fl, t) != t[k]) begin
        e.err++;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffc = k;
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Monitor: checks the sweep at the head of the scoreboard every cycle.
  exp_t       em;
  int         rel, mh, mlat;
  logic [1:0] mx, mfc;
  logic       mb, md, mp, mfv;
  logic [2:0] me;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      em   = q[0];
      mh   = em.inst ? 2 : 4;
      mlat = 4 * (mh + 1);
      rel  = cyc - em.s;
      mx  = em.inst ? x_b : x_a;       mb  = em.inst ? busy_b : busy_a;
      md  = em.inst ? done_b : done_a; mp  = em.inst ? pass_b : pass_a;
      me  = em.inst ? err_b : err_a;   mfv = em.inst ? ffv_b : ffv_a;
      mfc = em.inst ? ffc_b : ffc_a;
      if (rel >= 0 && rel < mlat) begin
        chk("busy_during_sweep", int'(mb), 1);
        chk("done_during_sweep", int'(md), 0);
        chk("x_schedule", int'(mx), rel / (mh + 1));
      end else if (rel == mlat) begin
        chk("busy_at_done", int'(mb), 0);
        chk("done_latency", int'(md), 1);
        chk("x_final", int'(mx), 3);
        chk("err_count", int'(me), em.err);
        chk("first_fail_valid", int'(mfv), int'(em.ffv));
        chk("first_fail_code", int'(mfc), em.ffc);
        chk("pass", int'(mp), int'(em.pass));
        void'(q.pop_front());
      end
    end
  end

  task automatic set_start(int inst, logic v);
    if (inst != 0) start_b = v;
    else start_a = v;
  endtask

  task automatic reset_checks();
    chk("reset_outputs_a", int'({x_a, busy_a, done_a, pass_a, err_a, ffv_a, ffc_a}), 0);
    chk("reset_outputs_b", int'({x_b, busy_b, done_b, pass_b, err_b, ffv_b, ffc_b}), 0);
  endtask

  // spur: raise start for one cycle after edge s+spur (0 = none), must be < latency.
  task automatic run(int inst, int md, int d, logic [3:0] fl, int spur);
    int s, lat;
    lat = inst ? 12 : 20;
    mode = md; dly = d; flip = fl;
    repeat (5) @(negedge clk);
    s = cyc + 1;
    q.push_back(predict(inst, s, prev_x[inst], md, d, fl));
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    for (int r = 1; r <= lat; r++) begin
      @(negedge clk);
      set_start(inst, r == spur);
    end
    set_start(inst, 1'b0);
    prev_x[inst] = 3;
  endtask

  initial begin
    int s, inst, lat, spur;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    run(0, 0, 0, 4'd0, 0);
    run(0, 1, 0, 4'd0, 0);
    run(1, 0, 3, 4'd0, 0);
    run(1, 0, 3, 4'd0, 0);
    run(0, 0, 3, 4'd0, 0);
    run(0, 0, 0, 4'd0, 9);

    // Reset in the middle of the x=2 hold window, with start asserted too.
    mode = 0; dly = 0;
    repeat (5) @(negedge clk);
    s = cyc + 1;
    q.push_back(predict(0, s, prev_x[0], 0, 0, 4'd0));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (11) @(negedge clk);
    chk("x_before_reset", int'(x_a), 2);
    q.delete();
    rst_n = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start_a = 1'b0;
    reset_checks();
    prev_x[0] = 0;
    prev_x[1] = 0;
    run(0, 0, 0, 4'd0, 0);

    // start held high across DONE restarts on the very next edge.
    repeat (5) @(negedge clk);
    s = cyc + 1;
    q.push_back(predict(0, s, prev_x[0], 0, 0, 4'd0));
    q.push_back(predict(0, s + 21, 3, 0, 0, 4'd0));
    start_a = 1'b1;
    repeat (22) @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    prev_x[0] = 3;

    for (int n = 0; n < 30; n++) begin
      inst = int'($urandom_range(0, 1));
      lat  = inst ? 12 : 20;
      spur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat - 1)) : 0;
      run(inst, int'($urandom_range(0, 3)), 3 * int'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), spur);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
